// File: rtl/lm80c_kbd_pkg.sv
// ---------------------------------------------------------------------------
// lm80c_kbd_pkg
// Shared types, constants and the PS/2-to-matrix key map used by the
// emulated keyboard matrix (ps2_key_matrix and its event FIFO).
//   kbd_evt_t   : queued matrix event {press, row, col}
//   kbd_map_t   : key map lookup result {hit, row, col}
//   kbd_state_t : event-apply FSM states
//   kbd_map()   : 16-bit PS/2 code -> matrix position (hit=0 if unmapped)
// ---------------------------------------------------------------------------
package lm80c_kbd_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int         EVT_W   = 7;

   typedef struct packed {
      logic       press;
      logic [2:0] row;
      logic [2:0] col;
   } kbd_evt_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] row;
      logic [2:0] col;
   } kbd_map_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_HOLD  = 2'd2
   } kbd_state_t;

   function automatic kbd_map_t kbd_pos(input logic [2:0] row, input logic [2:0] col);
      kbd_map_t m;
      m.hit = 1'b1;
      m.row = row;
      m.col = col;
      return m;
   endfunction

   // Extended keys carry E0 in the upper byte, so the same scancode byte can
   // map to different positions depending on the prefix.
   function automatic kbd_map_t kbd_map(input logic [15:0] code);
      kbd_map_t m;
      m = '0;
      case (code)
         16'h0066: m = kbd_pos(3'd0, 3'd0);   // Backspace
         16'h005A: m = kbd_pos(3'd0, 3'd1);   // Enter
         16'h0029: m = kbd_pos(3'd0, 3'd2);   // Space
         16'h0076: m = kbd_pos(3'd0, 3'd3);   // Esc
         16'hE06B: m = kbd_pos(3'd0, 3'd4);   // Left
         16'hE074: m = kbd_pos(3'd0, 3'd5);   // Right
         16'hE072: m = kbd_pos(3'd0, 3'd6);   // Down
         16'hE075: m = kbd_pos(3'd0, 3'd7);   // Up
         16'h001B: m = kbd_pos(3'd1, 3'd0);   // S
         16'h0023: m = kbd_pos(3'd1, 3'd1);   // D
         16'h001C: m = kbd_pos(3'd1, 3'd2);   // A
         16'h0015: m = kbd_pos(3'd1, 3'd3);   // Q
         16'h001D: m = kbd_pos(3'd1, 3'd4);   // W
         16'h001A: m = kbd_pos(3'd1, 3'd5);   // Z
         16'h0022: m = kbd_pos(3'd1, 3'd6);   // X
         16'h0012: m = kbd_pos(3'd1, 3'd7);   // LShift
         default:  m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo
// Synchronous first-word-fall-through FIFO holding matrix events.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write request and data; accepted when not full, or when a
//                pop in the same cycle frees the slot
//   pop, dout  : read request; dout always shows the head entry
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module kbd_event_fifo
   import lm80c_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = EVT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_key_matrix.sv
// ---------------------------------------------------------------------------
// ps2_key_matrix
// Turns decoded PS/2 key events into an emulated 8x8 key matrix scanned by
// the CPU through the PIO. Events are queued and applied one at a time with
// a minimum dwell so polling firmware sees every press and release.
//   clk, reset  : clock, asynchronous active-high reset
//   key_valid   : one-cycle strobe qualifying key_code/key_status
//   key_code    : {E0 if extended else 00, scancode byte}
//   key_status  : 1 = press, 0 = release
//   row_sel     : active-low row select from PIO port A
//   col_out     : active-low column sense to PIO port B (registered)
//   overflow    : sticky, an event was dropped on a full queue
// ---------------------------------------------------------------------------
module ps2_key_matrix
   import lm80c_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [15:0] key_code,
   input  logic        key_status,
   input  logic [7:0]  row_sel,
   output logic [7:0]  col_out,
   output logic        overflow
);

   localparam int               CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES - 1);

   kbd_state_t        state;
   logic [CW-1:0]     hold_cnt;
   logic [7:0][7:0]   matrix;        // [row][col], 1 = key down
   logic              clear_pend;

   kbd_map_t          map_res;
   kbd_evt_t          push_evt;
   kbd_evt_t          head;
   logic [EVT_W-1:0]  fifo_din;
   logic [EVT_W-1:0]  fifo_dout;
   logic              is_prefix;
   logic              push_req;
   logic              pop;
   logic              drop;
   logic              full;
   logic              empty;
   logic [7:0]        col_next;

   // Input filter: prefix bytes arrive as their own strobes and carry no key.
   assign is_prefix = (key_code[7:0] == PS2_EXT) || (key_code[7:0] == PS2_BRK);
   assign map_res   = kbd_map(key_code);
   assign push_req  = key_valid & ~is_prefix & map_res.hit;

   assign push_evt.press = key_status;
   assign push_evt.row   = map_res.row;
   assign push_evt.col   = map_res.col;
   assign fifo_din       = push_evt;
   assign head           = fifo_dout;

   assign pop  = (state == S_APPLY);
   // A pop in the same cycle frees a slot, so only a true overflow drops.
   assign drop = push_req & full & ~pop;

   kbd_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (EVT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         matrix     <= '0;
         clear_pend <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  state <= S_APPLY;
               end else if (clear_pend) begin
                  // After an overflow the matrix may hold keys whose release
                  // was lost; releasing everything beats a stuck key.
                  matrix     <= '0;
                  clear_pend <= 1'b0;
                  hold_cnt   <= HOLD_LOAD;
                  state      <= S_HOLD;
               end
            end
            S_APPLY: begin
               matrix[head.row][head.col] <= head.press;
               hold_cnt                   <= HOLD_LOAD;
               state                      <= S_HOLD;
            end
            S_HOLD: begin
               if (hold_cnt == '0) state <= S_IDLE;
               else                hold_cnt <= hold_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase

         // Placed last so a drop in the same cycle as the clear re-arms it.
         if (drop) begin
            overflow   <= 1'b1;
            clear_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      col_next = 8'hFF;
      for (int r = 0; r < 8; r++) begin
         if (!row_sel[r]) col_next = col_next & ~matrix[r];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) col_out <= 8'hFF;
      else       col_out <= col_next;
   end

endmodule
